csa_sub_28b_pipe: RTL and testbench

- 28-bit pipelined subtractor computing diff = a - b - borrow_in using the carry-select structure in the inverse direction: a + ~b + ~borrow_in.
- Three register stages with a valid/ready handshake on both sides, so it can sit directly in a stream datapath next to the registered carry-select adders.
- Full throughput of one operation per clock. Backpressure is propagated stage by stage.

---
 rtl/csa_sub_28b_pipe.sv | 168 ++++++++++++++++
 tb/tb_csa_sub_28b_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_sub_28b_pipe.sv
// Three-stage pipelined subtractor: diff = a - b - borrow_in via a + ~b + ~borrow_in.
// Lower half resolved in stage 2, upper half precomputed for both carries and selected in stage 3.
module csa_sub_28b_pipe #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned LO_W  = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_out_o,
    output logic             zero_o
);

    localparam int unsigned HI_W = WIDTH - LO_W;
    localparam logic [HI_W:0] HiOne = 1;

    // Stage valids and advance enables
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic v3_q, v3_d;
    logic adv1, adv2, adv3;
    logic in_xfer;

    // Stage 1: operands with b and borrow already inverted
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_nb_q, s1_nb_d;
    logic             s1_c0_q, s1_c0_d;

    // Stage 2: resolved low half, both candidate high halves
    logic [LO_W-1:0]  s2_lo_q, s2_lo_d;
    logic             s2_cm_q, s2_cm_d;
    logic [HI_W-1:0]  s2_hi0_q, s2_hi0_d;
    logic [HI_W-1:0]  s2_hi1_q, s2_hi1_d;
    logic             s2_c0_q, s2_c0_d;
    logic             s2_c1_q, s2_c1_d;

    // Stage 3: output registers
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [LO_W:0]    lo_sum;
    logic [HI_W:0]    hi0_sum;
    logic [HI_W:0]    hi1_sum;
    logic [HI_W-1:0]  hi_sel;
    logic             cout_sel;

    // Backpressure ripples from the output towards the input; in_valid never feeds in_ready.
    always_comb begin
        adv3    = !v3_q || out_ready_i;
        adv2    = !v2_q || adv3;
        adv1    = !v1_q || adv2;
        in_xfer = in_valid_i && adv1;
    end

    assign in_ready_o = adv1;

    always_comb begin
        lo_sum  = {1'b0, s1_a_q[LO_W-1:0]} + {1'b0, s1_nb_q[LO_W-1:0]}
                + {{LO_W{1'b0}}, s1_c0_q};
        hi0_sum = {1'b0, s1_a_q[WIDTH-1:LO_W]} + {1'b0, s1_nb_q[WIDTH-1:LO_W]};
        hi1_sum = {1'b0, s1_a_q[WIDTH-1:LO_W]} + {1'b0, s1_nb_q[WIDTH-1:LO_W]} + HiOne;
    end

    always_comb begin
        hi_sel   = s2_cm_q ? s2_hi1_q : s2_hi0_q;
        cout_sel = s2_cm_q ? s2_c1_q : s2_c0_q;
    end

    // Stage 1 next state
    always_comb begin
        v1_d    = v1_q;
        s1_a_d  = s1_a_q;
        s1_nb_d = s1_nb_q;
        s1_c0_d = s1_c0_q;
        if (in_xfer) begin
            v1_d    = 1'b1;
            s1_a_d  = a_i;
            s1_nb_d = ~b_i;
            s1_c0_d = ~borrow_in_i;
        end else if (adv1) begin
            v1_d = 1'b0;
        end
    end

    // Stage 2 next state
    always_comb begin
        v2_d     = v2_q;
        s2_lo_d  = s2_lo_q;
        s2_cm_d  = s2_cm_q;
        s2_hi0_d = s2_hi0_q;
        s2_hi1_d = s2_hi1_q;
        s2_c0_d  = s2_c0_q;
        s2_c1_d  = s2_c1_q;
        if (adv2) begin
            v2_d     = v1_q;
            s2_lo_d  = lo_sum[LO_W-1:0];
            s2_cm_d  = lo_sum[LO_W];
            s2_hi0_d = hi0_sum[HI_W-1:0];
            s2_hi1_d = hi1_sum[HI_W-1:0];
            s2_c0_d  = hi0_sum[HI_W];
            s2_c1_d  = hi1_sum[HI_W];
        end
    end

    // Stage 3 next state; carry out of a + ~b + ~bin is the inverse of the borrow
    always_comb begin
        v3_d     = v3_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        if (adv3) begin
            v3_d     = v2_q;
            diff_d   = {hi_sel, s2_lo_q};
            borrow_d = ~cout_sel;
            zero_d   = ({hi_sel, s2_lo_q} == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s1_a_q   <= '0;
            s1_nb_q  <= '0;
            s1_c0_q  <= 1'b0;
            s2_lo_q  <= '0;
            s2_cm_q  <= 1'b0;
            s2_hi0_q <= '0;
            s2_hi1_q <= '0;
            s2_c0_q  <= 1'b0;
            s2_c1_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            s1_a_q   <= s1_a_d;
            s1_nb_q  <= s1_nb_d;
            s1_c0_q  <= s1_c0_d;
            s2_lo_q  <= s2_lo_d;
            s2_cm_q  <= s2_cm_d;
            s2_hi0_q <= s2_hi0_d;
            s2_hi1_q <= s2_hi1_d;
            s2_c0_q  <= s2_c0_d;
            s2_c1_q  <= s2_c1_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid_o  = v3_q;
    assign diff_o       = diff_q;
    assign borrow_out_o = borrow_q;
    assign zero_o       = zero_q;

endmodule

// File: tb/tb_csa_sub_28b_pipe.sv
// Directed and random stream bench for csa_sub_28b_pipe with an in-order scoreboard.
module tb_csa_sub_28b_pipe;

    localparam int W = 28;
    localparam int NRand = 10000;

    logic         clk;
    logic         rstn;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         borrow_in_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] diff_o;
    logic         borrow_out_o;
    logic         zero_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [W:0] res;
        logic       zero;
    } exp_t;
    exp_t exp_q[$];

    csa_sub_28b_pipe #(.WIDTH(W), .LO_W(14)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .borrow_in_i  (borrow_in_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .diff_o       (diff_o),
        .borrow_out_o (borrow_out_o),
        .zero_o       (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bit W is the borrow: the 29-bit difference goes negative exactly on underflow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    endfunction

    // Inputs change only at posedge+1, so negedge values are those seen at the next edge.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("scb_unexpected", {31'b0, out_valid_o}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("scb_diff", {4'b0, diff_o}, {4'b0, e.res[W-1:0]});
                    check_eq("scb_borrow", {31'b0, borrow_out_o}, {31'b0, e.res[W]});
                    check_eq("scb_zero", {31'b0, zero_o}, {31'b0, e.zero});
                end
            end
            if (in_valid_i && in_ready_o) begin
                exp_t e;
                e.res  = ref_sub(a_i, b_i, borrow_in_i);
                e.zero = (e.res[W-1:0] == '0);
                exp_q.push_back(e);
            end
        end
    end

    task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bi, input logic [W-1:0] exp_d, input logic exp_bo,
                           input logic exp_z);
        int n;
        @(posedge clk); #1;
        a_i = a; b_i = b; borrow_in_i = bi; in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, {31'b0, in_ready_o}, 32'h1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, {31'b0, out_valid_o}, 32'h1);
        check_eq({tag, "_diff"}, {4'b0, diff_o}, {4'b0, exp_d});
        check_eq({tag, "_borrow"}, {31'b0, borrow_out_o}, {31'b0, exp_bo});
        check_eq({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp_z});
    endtask

    initial begin
        int idx;
        int sent;
        int cyc;
        logic [W:0] r0;

        rstn = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        a_i = '0; b_i = '0; borrow_in_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", {31'b0, out_valid_o}, 32'h0);
        check_eq("rst_diff", {4'b0, diff_o}, 32'h0);
        check_eq("rst_borrow", {31'b0, borrow_out_o}, 32'h0);
        check_eq("rst_zero", {31'b0, zero_o}, 32'h0);
        check_eq("rst_in_ready", {31'b0, in_ready_o}, 32'h1);

        // Latency: accepted at edge 1, visible after edge 3
        @(posedge clk); #1;
        a_i = 28'd5; b_i = 28'd3; borrow_in_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        check_eq("lat_e1_valid", {31'b0, out_valid_o}, 32'h0);
        @(posedge clk); #1;
        check_eq("lat_e2_valid", {31'b0, out_valid_o}, 32'h0);
        @(posedge clk); #1;
        check_eq("lat_e3_valid", {31'b0, out_valid_o}, 32'h1);
        check_eq("lat_diff", {4'b0, diff_o}, 32'h0000002);
        check_eq("lat_borrow", {31'b0, borrow_out_o}, 32'h0);
        check_eq("lat_zero", {31'b0, zero_o}, 32'h0);

        run_vec("under1", 28'd3, 28'd5, 1'b0, 28'hFFFFFFE, 1'b1, 1'b0);
        run_vec("under2", 28'd0, 28'd0, 1'b1, 28'hFFFFFFF, 1'b1, 1'b0);
        run_vec("xhalf", 28'h0004000, 28'h0000001, 1'b0, 28'h0003FFF, 1'b0, 1'b0);
        run_vec("zero", 28'hABCDEF1, 28'hABCDEF1, 1'b0, 28'h0000000, 1'b0, 1'b1);
        run_vec("maxa", 28'hFFFFFFF, 28'h0000000, 1'b0, 28'hFFFFFFF, 1'b0, 1'b0);
        run_vec("maxb", 28'h0000000, 28'hFFFFFFF, 1'b0, 28'h0000001, 1'b1, 1'b0);
        run_vec("msb", 28'h8000000, 28'h7FFFFFF, 1'b1, 28'h0000000, 1'b0, 1'b1);
        run_vec("bin", 28'h1234567, 28'h0000567, 1'b1, 28'h1233FFF, 1'b0, 1'b0);

        // Backpressure: 10 back-to-back beats, consumer stalled for 6 cycles
        repeat (4) @(posedge clk);
        idx = 0;
        r0  = ref_sub(28'h0000107, 28'h0000000, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready_i = (c >= 6);
            in_valid_i  = (idx < 10);
            a_i         = 28'(idx * 28'h100 + 28'h107);
            b_i         = 28'(idx * 3);
            borrow_in_i = idx[0];
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                check_eq("bp_in_ready", {31'b0, in_ready_o}, 32'h0);
                check_eq("bp_hold_valid", {31'b0, out_valid_o}, 32'h1);
                check_eq("bp_hold_diff", {4'b0, diff_o}, {4'b0, r0[W-1:0]});
            end
            if (c == 5) check_eq("bp_accepted", idx, 3);
            if (in_valid_i && in_ready_o) idx++;
        end
        in_valid_i = 1'b0;
        check_eq("bp_all_sent", idx, 10);
        check_eq("bp_drained", exp_q.size(), 0);

        // Random stream with random bubbles and backpressure
        sent = 0;
        cyc  = 0;
        while ((sent < NRand || exp_q.size() != 0) && cyc < 60000) begin
            @(posedge clk); #1;
            out_ready_i = ($urandom_range(0, 3) != 0);
            in_valid_i  = (sent < NRand) && ($urandom_range(0, 3) != 0);
            a_i         = W'($urandom());
            b_i         = ($urandom_range(0, 15) == 0) ? a_i : W'($urandom());
            borrow_in_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid_i && in_ready_o) sent++;
            cyc++;
        end
        in_valid_i = 1'b0;
        check_eq("rand_sent", sent, NRand);
        check_eq("rand_drained", exp_q.size(), 0);

        // Reset with three beats in flight
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            a_i = 28'(28'h0100000 + k); b_i = 28'(k); borrow_in_i = 1'b0;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        check_eq("mid_pre_valid", {31'b0, out_valid_o}, 32'h1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_valid", {31'b0, out_valid_o}, 32'h0);
        check_eq("mid_rst_diff", {4'b0, diff_o}, 32'h0);
        check_eq("mid_rst_in_ready", {31'b0, in_ready_o}, 32'h1);
        rstn = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("mid_no_stale", {31'b0, out_valid_o}, 32'h0);
        end
        check_eq("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
